// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces two sensor lines, queues accepted
// coins in a small FIFO and releases them as single-cycle codes with an idle gap.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin5_raw,
  input  logic                         coin10_raw,
  input  logic                         enable,
  output logic [1:0]                   coin_code,
  output logic                         reject,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AW + 1;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StEmit, StGap} state_e;

  // Bit 0 is the 5 rs line, bit 1 the 10 rs line.
  logic [1:0]     raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q, deb_d, deb_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];
  logic [1:0]     rise;

  logic                  push, push_ok, drop, pop, full;
  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  reject_q, reject_d;

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [1:0]      coin_code_q, coin_code_d;

  assign raw = {coin10_raw, coin5_raw};

  // Counter runs only while the synchronised level disagrees with the debounced one.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign rise     = deb_q & ~deb_prev_q;
  assign reject_d = &rise;
  assign push     = ^rise;
  assign full     = (count_q == CntFull);
  assign push_ok  = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push_ok) begin
      mem_d[wptr_q] = rise[1];
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Popping only from the registered count means an empty FIFO never bypasses.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && enable) begin
          pop     = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        gap_d   = GapLast;
        state_d = StGap;
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    coin_code_d = 2'b00;
    if (pop) begin
      coin_code_d = mem_q[rptr_q] ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
      mem_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      reject_q    <= 1'b0;
      coin_code_q <= 2'b00;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      reject_q    <= reject_d;
      coin_code_q <= coin_code_d;
    end
  end

  assign coin_code  = coin_code_q;
  assign reject     = reject_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: expected codes queue on insertion and are
// popped by a negedge monitor that also polices pulse widths and gaps.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       c5, c10, en;
  logic [1:0] coin_code;
  logic       reject;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks       = 0;
  int failures     = 0;
  int codes_seen   = 0;
  int rejects_seen = 0;
  int snap_codes, snap_rej;

  logic [1:0] sb [$];
  logic [1:0] prev_code = 2'b00;
  logic       prev_rej  = 1'b0;
  logic [1:0] exp_code;

  coin_acceptor dut (
    .clk       (clk),
    .rst       (rst),
    .coin5_raw (c5),
    .coin10_raw(c10),
    .enable    (en),
    .coin_code (coin_code),
    .reject    (reject),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Insert one coin: raw line high for hi cycles, then low for lo cycles.
  task automatic coin(input bit ten, input bit expect_code, input int hi, input int lo);
    if (expect_code) sb.push_back(ten ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    if (ten) c10 = 1'b1; else c5 = 1'b1;
    repeat (hi) @(posedge clk);
    #1 c5 = 1'b0; c10 = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    check(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_code = 2'b00;
      prev_rej  = 1'b0;
    end else begin
      if (coin_code != 2'b00) begin
        check("zero_before_code", prev_code, 2'b00);
        exp_code = (sb.size() != 0) ? sb.pop_front() : 2'b11;
        check("code", coin_code, exp_code);
        codes_seen++;
      end
      if (reject) begin
        check("reject_width", prev_rej, 1'b0);
        rejects_seen++;
      end
      prev_code = coin_code;
      prev_rej  = reject;
    end
  end

  initial begin
    int n;
    rst = 1'b0; c5 = 1'b0; c10 = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_code", coin_code, 2'b00);
    check("rst_reject", reject, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);

    // 1: single 5 rs coin, exact latency and one-cycle width
    sb.push_back(2'b01);
    @(posedge clk); #1 c5 = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("t1_count_after_push", fifo_count, 3'd1);
    check("t1_code_early", coin_code, 2'b00);
    @(negedge clk);
    check("t1_code_valid", coin_code, 2'b01);
    @(negedge clk);
    check("t1_code_width", coin_code, 2'b00);
    @(posedge clk); #1 c5 = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t1_count_zero", fifo_count, 3'd0);
    check("t1_codes", codes_seen, 1);

    // 2: 3-cycle glitch ignored, then clean 10 rs coin
    @(posedge clk); #1 c10 = 1'b1;
    repeat (3) @(posedge clk);
    #1 c10 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t2_glitch_count", fifo_count, 3'd0);
    check("t2_glitch_codes", codes_seen, 1);
    check("t2_glitch_reject", rejects_seen, 0);
    coin(1'b1, 1'b1, 10, 12);
    drain("t2_drain");
    check("t2_codes", codes_seen, 2);

    // 3: hold four coins, then release in order
    en = 1'b0;
    coin(1'b0, 1'b1, 8, 8);
    coin(1'b1, 1'b1, 8, 8);
    coin(1'b0, 1'b1, 8, 8);
    coin(1'b1, 1'b1, 8, 8);
    @(negedge clk);
    check("t3_count_full", fifo_count, 3'd4);
    check("t3_code_held", coin_code, 2'b00);
    check("t3_no_overflow", overflow, 1'b0);
    @(posedge clk); #1 en = 1'b1;
    drain("t3_drain");
    check("t3_codes", codes_seen, 6);
    check("t3_count_empty", fifo_count, 3'd0);

    // 4: fifth coin overflows and is dropped; overflow is sticky
    en = 1'b0;
    coin(1'b0, 1'b1, 8, 8);
    coin(1'b1, 1'b1, 8, 8);
    coin(1'b0, 1'b1, 8, 8);
    coin(1'b1, 1'b1, 8, 8);
    @(negedge clk);
    check("t4_overflow_before", overflow, 1'b0);
    coin(1'b0, 1'b0, 8, 8);
    @(negedge clk);
    check("t4_overflow_set", overflow, 1'b1);
    check("t4_count_full", fifo_count, 3'd4);
    @(posedge clk); #1 en = 1'b1;
    drain("t4_drain");
    check("t4_codes", codes_seen, 10);
    check("t4_overflow_sticky", overflow, 1'b1);

    // 5: simultaneous rise on both lines -> single reject, nothing queued
    snap_codes = codes_seen;
    @(posedge clk); #1 c5 = 1'b1; c10 = 1'b1;
    repeat (10) @(posedge clk);
    #1 c5 = 1'b0; c10 = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t5_rejects", rejects_seen, 1);
    check("t5_no_code", codes_seen, snap_codes);
    check("t5_count", fifo_count, 3'd0);

    // 6: reset in the middle of an emit with coins queued
    en = 1'b0;
    coin(1'b0, 1'b1, 8, 8);
    coin(1'b1, 1'b1, 8, 8);
    coin(1'b0, 1'b1, 8, 8);
    @(negedge clk);
    check("t6_count", fifo_count, 3'd3);
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (coin_code == 2'b00 && n < 100);
    check("t6_emit_seen", (coin_code != 2'b00), 1'b1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_code", coin_code, 2'b00);
    check("t6_rst_count", fifo_count, 3'd0);
    check("t6_rst_overflow", overflow, 1'b0);
    sb.delete();
    snap_codes = codes_seen;
    snap_rej   = rejects_seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t6_no_codes_after", codes_seen, snap_codes);
    check("t6_no_reject_after", rejects_seen, snap_rej);
    check("t6_count_after", fifo_count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
